bls_multicycle_sub: RTL and testbench

//  Parametrised successor to the 4-bit borrow-lookahead subtractor. Computes D = M - S - Bin for a

---
 rtl/bls_multicycle_sub.sv | 168 ++++++++++++++++
 tb/tb_bls_multicycle_sub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bls_multicycle_sub.sv
// Multicycle borrow-lookahead subtractor: D = M - S - Bin, CHUNK bits per clock through one
// shared lookahead slice, with valid/ready handshakes and borrow/overflow/zero flags.
module bls_multicycle_sub #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_m,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_opM;
  logic [WIDTH-1:0] r_opS;
  logic             r_br;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_runChunk;
  logic             w_lastChunk;
  logic [CHUNK-1:0] w_mChunk;
  logic [CHUNK-1:0] w_sChunk;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK:0]   w_b;
  logic [CHUNK-1:0] w_dChunk;
  logic [WIDTH-1:0] w_workNext;
  logic             w_acc;
  logic             w_bit;
  logic             w_ovfNext;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_runChunk  = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_runChunk = 1'b1;
        if (r_k == LAST_K) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_lastChunk = (r_k == LAST_K);
  assign w_mChunk    = r_opM[int'(r_k)*CHUNK +: CHUNK];
  assign w_sChunk    = r_opS[int'(r_k)*CHUNK +: CHUNK];
  assign w_p         = w_mChunk ^ w_sChunk;
  assign w_g         = ~w_mChunk & w_sChunk;

  // Each borrow is a flat sum of products over lower generates and the chunk borrow-in.
  always_comb begin
    w_b    = '0;
    w_acc  = 1'b1;
    w_bit  = 1'b0;
    w_b[0] = r_br;
    for (int i = 1; i <= CHUNK; i++) begin
      w_acc = 1'b1;
      w_bit = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        w_bit = w_bit | (w_acc & w_g[j]);
        w_acc = w_acc & ~w_p[j];
      end
      w_bit  = w_bit | (w_acc & r_br);
      w_b[i] = w_bit;
    end
  end

  assign w_dChunk = w_p ^ w_b[CHUNK-1:0];

  always_comb begin
    w_workNext = r_work;
    w_workNext[int'(r_k)*CHUNK +: CHUNK] = w_dChunk;
  end

  assign w_ovfNext = (r_opM[WIDTH-1] ^ r_opS[WIDTH-1]) & (w_workNext[WIDTH-1] ^ r_opM[WIDTH-1]);

  // Chunks build up in r_work; the visible result only updates once the last chunk lands.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_opM  <= '0;
      r_opS  <= '0;
      r_br   <= 1'b0;
      r_k    <= '0;
      r_work <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_opM <= i_m;
      r_opS <= i_s;
      r_br  <= i_bin;
      r_k   <= '0;
    end else if (w_runChunk) begin
      r_work <= w_workNext;
      r_br   <= w_b[CHUNK];
      if (w_lastChunk) begin
        r_d    <= w_workNext;
        r_bout <= w_b[CHUNK];
        r_ovf  <= w_ovfNext;
        r_zero <= ~|w_workNext;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign o_d    = r_d;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_bls_multicycle_sub.sv
// Self-checking bench for bls_multicycle_sub (12/4): directed corner cases plus a randomized
// handshake run scored against an arithmetic reference model.
module tb_bls_multicycle_sub;

  localparam int WIDTH = 12;
  localparam int CHUNK = 4;
  localparam int NRAND = 3000;

  logic             clk = 1'b0;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] s;
  logic             bin;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  int checks = 0;
  int errors = 0;

  bls_multicycle_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_in_valid (inValid),
    .o_in_ready (inReady),
    .i_m        (m),
    .i_s        (s),
    .i_bin      (bin),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_d        (d),
    .o_bout     (bout),
    .o_ovf      (ovf),
    .o_zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic, signed view by sign extension.
  function automatic logic [14:0] refModel(input logic [WIDTH-1:0] rm, input logic [WIDTH-1:0] rs,
                                           input logic rb);
    int um, us, diff, sm, ss, sr;
    logic [WIDTH-1:0] rd;
    logic rbout, rovf, rzero;
    um    = int'(rm);
    us    = int'(rs);
    diff  = um - us - int'(rb);
    rd    = WIDTH'(diff & 32'hFFF);
    rbout = (diff < 0);
    sm    = (um >= 2048) ? um - 4096 : um;
    ss    = (us >= 2048) ? us - 4096 : us;
    sr    = sm - ss - int'(rb);
    rovf  = (sr > 2047) || (sr < -2048);
    rzero = (rd == '0);
    return {rzero, rovf, rbout, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair and waits for the result; latency counts edges after accept.
  task automatic applyStimulus(input logic [WIDTH-1:0] am, input logic [WIDTH-1:0] as, input logic ab,
                               output int latency);
    int guard;
    guard = 0;
    while (!inReady && guard < 20) begin
      tick();
      guard++;
    end
    if (!inReady) checkOutput("readyTimeout", 32'(inReady), 32'd1);
    inValid = 1'b1;
    m       = am;
    s       = as;
    bin     = ab;
    tick();
    inValid = 1'b0;
    latency = 0;
    while (!outValid && latency < 20) begin
      tick();
      latency++;
    end
    if (!outValid) checkOutput("validTimeout", 32'(outValid), 32'd1);
  endtask

  task automatic runDirected(input string tag, input logic [WIDTH-1:0] am, input logic [WIDTH-1:0] as,
                             input logic ab, input logic [WIDTH-1:0] expD, input logic expBout,
                             input logic expOvf, input logic expZero);
    int lat;
    applyStimulus(am, as, ab, lat);
    checkOutput({tag, ".latency"}, 32'(lat), 32'd3);
    checkOutput({tag, ".d"}, 32'(d), 32'(expD));
    checkOutput({tag, ".bout"}, 32'(bout), 32'(expBout));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(expZero));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput({tag, ".validDrop"}, 32'(outValid), 32'd0);
    checkOutput({tag, ".readyRise"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    logic [24:0] q[$];
    logic [24:0] entry;
    logic [14:0] exp;
    int lat, accepts, results, cycles;

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    m        = '0;
    s        = '0;
    bin      = 1'b0;
    tick();
    tick();
    checkOutput("reset.outValid", 32'(outValid), 32'd0);
    checkOutput("reset.inReady", 32'(inReady), 32'd1);
    checkOutput("reset.d", 32'(d), 32'd0);
    checkOutput("reset.flags", 32'({bout, ovf, zero}), 32'd0);
    rstN = 1'b1;

    runDirected("zeroResult", 12'h123, 12'h122, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1);
    runDirected("ripple", 12'h100, 12'h001, 1'b0, 12'h0FF, 1'b0, 1'b0, 1'b0);
    runDirected("underflow", 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
    runDirected("signedOvf", 12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1, 1'b0);
    runDirected("equalBin", 12'h5A5, 12'h5A5, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0);

    // Result must stay frozen while the consumer stalls, whatever the producer does.
    applyStimulus(12'h456, 12'h123, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      inValid = ~inValid;
      m       = WIDTH'($urandom);
      s       = WIDTH'($urandom);
      bin     = 1'($urandom);
      tick();
      checkOutput("stall.d", 32'(d), 32'h333);
      checkOutput("stall.flags", 32'({bout, ovf, zero}), 32'd0);
      checkOutput("stall.inReady", 32'(inReady), 32'd0);
      checkOutput("stall.outValid", 32'(outValid), 32'd1);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;

    // Abort mid-operation after one chunk has been processed.
    inValid = 1'b1;
    m       = 12'hABC;
    s       = 12'h123;
    bin     = 1'b0;
    tick();
    inValid = 1'b0;
    tick();
    rstN = 1'b0;
    tick();
    checkOutput("abort.outValid", 32'(outValid), 32'd0);
    checkOutput("abort.inReady", 32'(inReady), 32'd1);
    checkOutput("abort.d", 32'(d), 32'd0);
    rstN = 1'b1;
    runDirected("afterAbort", 12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0);

    accepts = 0;
    results = 0;
    cycles  = 0;
    while (results < NRAND && cycles < 60000) begin
      inValid  = (accepts < NRAND) ? 1'($urandom_range(0, 1)) : 1'b0;
      m        = WIDTH'($urandom);
      s        = WIDTH'($urandom);
      bin      = 1'($urandom);
      outReady = ($urandom_range(0, 3) != 0);
      if (inValid && inReady) begin
        q.push_back({bin, m, s});
        accepts++;
      end
      if (outValid && outReady) begin
        if (q.size() == 0) begin
          checkOutput("rand.spurious", 32'(q.size()), 32'd1);
        end else begin
          entry = q.pop_front();
          exp   = refModel(entry[23:12], entry[11:0], entry[24]);
          checkOutput("rand.d", 32'(d), 32'(exp[11:0]));
          checkOutput("rand.bout", 32'(bout), 32'(exp[12]));
          checkOutput("rand.ovf", 32'(ovf), 32'(exp[13]));
          checkOutput("rand.zero", 32'(zero), 32'(exp[14]));
        end
        results++;
      end
      tick();
      cycles++;
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("rand.results", 32'(results), 32'(NRAND));
    checkOutput("rand.accepts", 32'(accepts), 32'(NRAND));
    checkOutput("rand.leftover", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
